// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester side and transmitter side signals of uart_tx_arbiter.
// master is the arbiter view; slave is the view of the surrounding environment.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_CH = 4
);
    logic                  i_en;
    logic [NUM_CH*8-1:0]   i_ch_data;
    logic [NUM_CH-1:0]     i_ch_valid;
    logic [NUM_CH-1:0]     i_ch_last;
    logic [NUM_CH-1:0]     o_ch_ready;
    logic [NUM_CH-1:0]     o_grant;
    logic                  o_busy;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;

    modport master (
        input  i_en, i_ch_data, i_ch_valid, i_ch_last, i_tx_ready,
        output o_ch_ready, o_grant, o_busy, o_tx_data, o_tx_valid
    );

    modport slave (
        output i_en, i_ch_data, i_ch_valid, i_ch_last, i_tx_ready,
        input  o_ch_ready, o_grant, o_busy, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked scheduler sharing one UART transmitter among NUM_CH byte streams.
// Byte acceptance is inferred from the transmitter's ready dropping while a byte is offered.
module uart_tx_arbiter #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic               i_u_clk,
    input  logic               i_u_rst_n,
    uart_tx_arbiter_if.master  bus
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DRAIN} state_t;

    state_t              state, state_n;
    logic [NUM_CH-1:0]   grant, grant_n;
    logic [CH_W-1:0]     gidx, gidx_n;
    logic [CH_W-1:0]     last_grant, last_grant_n;
    logic [BW-1:0]       burst, burst_n;
    logic                r_last, r_last_n;
    logic [7:0]          tx_data, tx_data_n;
    logic                tx_valid, tx_valid_n;
    logic [CH_W-1:0]     sel;
    logic                sel_found;
    logic [7:0]          ch_byte [NUM_CH];

    for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_unpack
        assign ch_byte[k] = bus.i_ch_data[8*k +: 8];
    end

    // First valid channel after the previous owner, wrapping modulo NUM_CH.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            if (!sel_found && bus.i_ch_valid[CH_W'((32'(last_grant) + i) % NUM_CH)]) begin
                sel_found = 1'b1;
                sel       = CH_W'((32'(last_grant) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        gidx_n       = gidx;
        last_grant_n = last_grant;
        burst_n      = burst;
        r_last_n     = r_last;
        tx_data_n    = tx_data;
        tx_valid_n   = tx_valid;
        unique case (state)
            IDLE: begin
                if (bus.i_en && (|bus.i_ch_valid) && bus.i_tx_ready && sel_found) begin
                    grant_n = NUM_CH'(1) << sel;
                    gidx_n  = sel;
                    burst_n = '0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (bus.i_ch_valid[gidx]) begin
                    tx_data_n  = ch_byte[gidx];
                    r_last_n   = bus.i_ch_last[gidx];
                    tx_valid_n = 1'b1;
                    state_n    = SEND;
                end
            end
            SEND: begin
                // Ready falling while the byte is offered is the acceptance event.
                if (!bus.i_tx_ready) begin
                    tx_valid_n = 1'b0;
                    burst_n    = burst + BW'(1);
                    state_n    = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.i_tx_ready) begin
                    if (r_last || (burst == BW'(MAX_BURST))) begin
                        last_grant_n = gidx;
                        grant_n      = '0;
                        state_n      = IDLE;
                    end else begin
                        state_n = FETCH;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_u_clk or negedge i_u_rst_n) begin
        if (!i_u_rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            gidx       <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            burst      <= '0;
            r_last     <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            gidx       <= gidx_n;
            last_grant <= last_grant_n;
            burst      <= burst_n;
            r_last     <= r_last_n;
            tx_data    <= tx_data_n;
            tx_valid   <= tx_valid_n;
        end
    end

    // ready and busy decode from registered state only, never from inputs.
    assign bus.o_ch_ready = (state == FETCH) ? grant : '0;
    assign bus.o_busy     = (state != IDLE);
    assign bus.o_grant    = grant;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_tx_valid = tx_valid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queued byte sources, a frame-timed transmitter
// model and a packet-level round-robin reference that predicts the transmitted byte order.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned CH_W      = 2;
    localparam int unsigned MAX_BURST = 4;

    logic i_u_clk   = 1'b0;
    logic i_u_rst_n = 1'b0;

    always #5 i_u_clk = ~i_u_clk;

    uart_tx_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

    uart_tx_arbiter #(
        .NUM_CH   (NUM_CH),
        .CH_W     (CH_W),
        .MAX_BURST(MAX_BURST)
    ) u_dut (
        .i_u_clk  (i_u_clk),
        .i_u_rst_n(i_u_rst_n),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] src_d [NUM_CH][$];
    bit         src_l [NUM_CH][$];
    logic [7:0] mq_d  [NUM_CH][$];
    bit         mq_l  [NUM_CH][$];
    logic [7:0] exp_d [$];
    int         exp_c [$];
    int         m_ptr;

    bit bubbles, cts_block, en_rand, en_val, rand_frame;
    int cts_pct, tx_cnt, step_no, first_valid_step;
    int ready_cnt [NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_byte(input int ch, input logic [7:0] d, input bit l);
        src_d[ch].push_back(d);
        src_l[ch].push_back(l);
        mq_d[ch].push_back(d);
        mq_l[ch].push_back(l);
    endtask

    // Packet-level reference: next non-empty channel after the pointer owns the line
    // until its last byte or MAX_BURST bytes, then the pointer moves to it.
    task automatic run_model();
        int c, n, busy_ch;
        bit done;
        forever begin
            busy_ch = 0;
            for (int k = 0; k < NUM_CH; k++) if (mq_d[k].size() > 0) busy_ch++;
            if (busy_ch == 0) break;
            c = -1;
            for (int i = 1; i <= NUM_CH; i++)
                if (c < 0 && mq_d[(m_ptr + i) % NUM_CH].size() > 0) c = (m_ptr + i) % NUM_CH;
            n = 0;
            done = 1'b0;
            while (!done) begin
                exp_d.push_back(mq_d[c].pop_front());
                exp_c.push_back(c);
                n++;
                done = mq_l[c].pop_front() || (n == MAX_BURST);
            end
            m_ptr = c;
        end
    endtask

    task automatic step();
        logic [NUM_CH-1:0] s_rdy, s_val, s_grant;
        logic [7:0]        s_txd, ed;
        bit                s_acc;
        int                ec;
        @(negedge i_u_clk);
        for (int k = 0; k < NUM_CH; k++) begin
            if (src_d[k].size() > 0) begin
                bus.i_ch_valid[k]       = !(bubbles && bus.o_grant[k] && ($urandom_range(0, 3) == 0));
                bus.i_ch_data[8*k +: 8] = src_d[k][0];
                bus.i_ch_last[k]        = src_l[k][0];
            end else begin
                bus.i_ch_valid[k]       = 1'b0;
                bus.i_ch_data[8*k +: 8] = 8'h00;
                bus.i_ch_last[k]        = 1'b0;
            end
        end
        bus.i_en       = en_rand ? ($urandom_range(0, 3) != 0) : en_val;
        bus.i_tx_ready = (tx_cnt == 0);
        s_rdy   = bus.o_ch_ready;
        s_val   = bus.i_ch_valid;
        s_grant = bus.o_grant;
        s_txd   = bus.o_tx_data;
        s_acc   = bus.i_tx_ready && bus.o_tx_valid && !cts_block &&
                  ($urandom_range(0, 99) >= cts_pct);
        if (first_valid_step < 0 && bus.o_tx_valid) first_valid_step = step_no;
        for (int k = 0; k < NUM_CH; k++) ready_cnt[k] += s_rdy[k] ? 1 : 0;
        @(posedge i_u_clk);
        #1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (s_rdy[k] && s_val[k]) begin
                void'(src_d[k].pop_front());
                void'(src_l[k].pop_front());
            end
        end
        if (s_acc) begin
            if (exp_d.size() == 0) begin
                check("tx_extra_byte", 32'(s_txd), 32'hFFFF_FFFF);
            end else begin
                ed = exp_d.pop_front();
                ec = exp_c.pop_front();
                check("tx_byte", 32'(s_txd), 32'(ed));
                check("tx_grant", 32'(s_grant), 32'(1) << ec);
            end
            tx_cnt = rand_frame ? int'($urandom_range(1, 10)) : 10;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
        step_no++;
    endtask

    task automatic start_phase();
        run_model();
        step_no          = 0;
        first_valid_step = -1;
        for (int k = 0; k < NUM_CH; k++) ready_cnt[k] = 0;
    endtask

    task automatic finish_phase(input int budget);
        int n = 0;
        int left = 0;
        while ((exp_d.size() > 0 || tx_cnt > 0) && n < budget) begin
            step();
            n++;
        end
        check("phase_drained", 32'(exp_d.size()), 32'd0);
        for (int k = 0; k < NUM_CH; k++) left += src_d[k].size();
        check("sources_empty", 32'(left), 32'd0);
        step();
        step();
        check("idle_busy", 32'(bus.o_busy), 32'd0);
        check("idle_grant", 32'(bus.o_grant), 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, held, rc, seen;
        logic [7:0] d0;
        bus.i_en       = 1'b0;
        bus.i_ch_data  = '0;
        bus.i_ch_valid = '0;
        bus.i_ch_last  = '0;
        bus.i_tx_ready = 1'b1;
        bubbles = 0; cts_block = 0; en_rand = 0; en_val = 1; rand_frame = 0;
        cts_pct = 0; tx_cnt = 0; m_ptr = NUM_CH - 1;

        repeat (2) @(posedge i_u_clk);
        #1;
        check("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check("rst_tx_data",  32'(bus.o_tx_data),  32'd0);
        check("rst_grant",    32'(bus.o_grant),    32'd0);
        check("rst_ch_ready", 32'(bus.o_ch_ready), 32'd0);
        check("rst_busy",     32'(bus.o_busy),     32'd0);
        @(negedge i_u_clk);
        i_u_rst_n = 1'b1;

        // Single byte on ch2: two-cycle latency, one ready pulse.
        add_byte(2, 8'hA5, 1'b1);
        start_phase();
        finish_phase(200);
        check("first_valid_latency", 32'(first_valid_step), 32'd2);
        check("ch2_ready_cycles", 32'(ready_cnt[2]), 32'd1);

        // Three-byte packet on ch0 is not interrupted by a waiting ch1.
        add_byte(0, 8'h11, 1'b0);
        add_byte(0, 8'h22, 1'b0);
        add_byte(0, 8'h33, 1'b1);
        add_byte(1, 8'h44, 1'b1);
        start_phase();
        finish_phase(300);
        check("ch0_ready_cycles", 32'(ready_cnt[0]), 32'd3);

        // Six-byte packet on ch0 is split at MAX_BURST around ch1.
        for (int i = 0; i < 6; i++) add_byte(0, 8'(8'hB0 + i), i == 5);
        add_byte(1, 8'hC1, 1'b1);
        start_phase();
        finish_phase(500);

        // Every channel holding single-byte packets.
        for (int k = 0; k < NUM_CH; k++) add_byte(k, 8'(8'hD0 + k), 1'b1);
        add_byte(0, 8'hE0, 1'b1);
        start_phase();
        finish_phase(500);

        // Transmitter holds ready high without accepting for 50 cycles.
        add_byte(1, 8'h5C, 1'b1);
        cts_block = 1;
        start_phase();
        n = 0;
        while (!bus.o_tx_valid && n < 20) begin step(); n++; end
        check("cts_offer_seen", 32'(bus.o_tx_valid), 32'd1);
        d0   = bus.o_tx_data;
        rc   = ready_cnt[1];
        held = 0;
        repeat (50) begin
            step();
            if (bus.o_tx_valid && bus.o_tx_data == d0) held++;
        end
        check("cts_valid_held", 32'(held), 32'd50);
        check("cts_no_new_ready", 32'(ready_cnt[1]), 32'(rc));
        cts_block = 0;
        finish_phase(200);

        // Reset while ch3's byte is offered but not accepted, then gated arbitration.
        add_byte(3, 8'h3C, 1'b1);
        cts_block = 1;
        start_phase();
        n = 0;
        while (!bus.o_tx_valid && n < 20) begin step(); n++; end
        check("rst_mid_offer_seen", 32'(bus.o_grant), 32'b1000);
        @(negedge i_u_clk);
        i_u_rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check("mid_rst_tx_data",  32'(bus.o_tx_data),  32'd0);
        check("mid_rst_grant",    32'(bus.o_grant),    32'd0);
        check("mid_rst_ch_ready", 32'(bus.o_ch_ready), 32'd0);
        check("mid_rst_busy",     32'(bus.o_busy),     32'd0);
        for (int k = 0; k < NUM_CH; k++) begin
            src_d[k].delete();
            src_l[k].delete();
        end
        exp_d.delete();
        exp_c.delete();
        tx_cnt = 0; cts_block = 0; m_ptr = NUM_CH - 1;
        bus.i_ch_valid = '0;
        repeat (2) @(posedge i_u_clk);
        @(negedge i_u_clk);
        i_u_rst_n = 1'b1;
        en_val = 0;
        add_byte(0, 8'h0A, 1'b1);
        add_byte(3, 8'h3D, 1'b1);
        start_phase();
        seen = 0;
        repeat (20) begin
            step();
            if (bus.o_grant != '0 || bus.o_busy) seen = 1;
        end
        check("en_low_no_grant", 32'(seen), 32'd0);
        en_val = 1;
        finish_phase(300);

        // Randomised packets with valid bubbles, enable toggling, CTS stalls and frame lengths.
        bubbles = 1; en_rand = 1; cts_pct = 30; rand_frame = 1;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                n = int'($urandom_range(0, 3));
                for (int p = 0; p < n; p++) begin
                    int len = int'($urandom_range(1, 7));
                    for (int b = 0; b < len; b++) add_byte(k, 8'($urandom), b == len - 1);
                end
            end
            start_phase();
            finish_phase(8000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter among NUM_CH byte-stream requesters.
- Sits directly in front of the transmitter. Drives its data/valid inputs and infers byte acceptance from its registered ready output, which drops the cycle after acceptance and stays low for the whole frame.
- Grants are packet-locked: a requester keeps the transmitter until its byte flagged last has been sent, or until MAX_BURST bytes have been sent, whichever comes first.

Parameters:
- NUM_CH, 4: number of requesters (2..8).
- CH_W, 2: width of the channel index; equals clog2(NUM_CH).
- MAX_BURST, 16: maximum bytes per grant before forced re-arbitration (>=1).

Ports:
- i_u_clk  in  1  system clock.
- i_u_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  arbitration enable; gates new grants only.
- i_ch_data  in  NUM_CH*8  per-channel byte; channel k occupies bits [8k+7:8k].
- i_ch_valid  in  NUM_CH  per-channel byte valid.
- i_ch_last  in  NUM_CH  per-channel last-byte-of-packet flag; qualified by valid.
- o_ch_ready  out  NUM_CH  per-channel ready; one-hot or zero.
- o_grant  out  NUM_CH  one-hot current owner; zero when idle.
- o_busy  out  1  high in any state other than IDLE.
- o_tx_data  out  8  byte to the transmitter.
- o_tx_valid  out  1  byte valid to the transmitter.
- i_tx_ready  in  1  transmitter ready; low while a frame is in progress.

Behaviour:
- Reset values: o_tx_valid=0, o_tx_data=0, o_grant=0, o_ch_ready=0, o_busy=0, burst count=0, state=IDLE.
- Reset sets the round-robin pointer r_last_grant=NUM_CH-1, so the first grant goes to ch0.
- States: IDLE, FETCH, SEND, DRAIN. All outputs are registered except o_ch_ready and o_busy. Those are decoded from the registered state and grant only and never depend on inputs.
- IDLE:
  - Arbitrates when i_en=1, |i_ch_valid=1 and i_tx_ready=1.
  - Picks the first valid channel searching r_last_grant+1, r_last_grant+2, ... modulo NUM_CH.
  - Registers o_grant, clears the burst count, moves to FETCH.
- FETCH:
  - o_ch_ready[g]=1.
  - On i_ch_valid[g]=1: captures byte into o_tx_data, captures i_ch_last[g] into r_last, sets o_tx_valid=1, moves to SEND.
  - While i_ch_valid[g]=0: holds in FETCH; grant is kept (packet lock).
  - At most one upstream transfer per visit.
- SEND:
  - Holds o_tx_valid=1 with o_tx_data stable.
  - The first cycle with i_tx_ready=0 means the transmitter has accepted the byte. On that cycle: o_tx_valid<=0, burst count +1, move to DRAIN.
  - A CTS-blocked transmitter keeps ready high; SEND holds indefinitely.
- DRAIN:
  - Waits for i_tx_ready=1.
  - Then, if r_last=1 or burst count==MAX_BURST: r_last_grant<=g, o_grant<=0, move to IDLE.
  - Otherwise move to FETCH with the same grant.
- Timing:
  - Minimum IDLE to valid-visible latency: 2 cycles (IDLE->FETCH, FETCH->SEND).
  - One extra FETCH cycle separates consecutive bytes of a packet.
- The transmitter is never offered a byte while i_tx_ready=0: SEND is only entered from FETCH, and FETCH is only entered with ready high.
- i_en=0 blocks new grants from IDLE only. An active packet runs to last or MAX_BURST.
- Burst counter width is clog2(MAX_BURST+1). It never wraps, because it is compared before increment past MAX_BURST.
- A channel that raises valid while another owns the grant waits; no starvation under round-robin.
- Reset asserted mid-operation:
  - Immediately clears all outputs and state.
  - A byte already accepted by the transmitter completes on the line without further involvement.
  - A byte offered in SEND but not yet accepted is dropped.

Test Plan:
- ch2 sends 0xA5 with last=1. Transmitter model drops ready 1 cycle after accept, for 10 cycles.
  -> o_grant=4'b0100; o_ch_ready[2] high exactly 1 cycle; o_tx_data=0xA5 with valid until ready falls; o_busy low and o_grant=0 after ready returns.
- All four channels hold single-byte last=1 packets continuously.
  -> grants in order ch0, ch1, ch2, ch3, ch0; each byte accepted once.
- ch0 sends packet 0x11, 0x22, 0x33 (last on 0x33) while ch1 is valid from cycle 0.
  -> the transmitter sees 0x11, 0x22, 0x33, then ch1's byte; o_grant stays 4'b0001 throughout.
- MAX_BURST=2, ch0 sends a 5-byte packet, ch1 sends one byte.
  -> order: ch0 b0, b1, ch1, ch0 b2, b3, then ch1 or ch0 per round-robin.
- Transmitter ready held high for 50 cycles after SEND entry (CTS blocked).
  -> o_tx_valid stays high and o_tx_data stable; no further o_ch_ready pulse.
- Reset mid-SEND on ch3, then i_en=0 with ch0 valid.
  -> all outputs 0; no grant while i_en=0; after i_en=1, first grant is ch0.
